// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU-side widths, mode encodings and acc_feeder state encoding
package ppu_pkg;
  localparam int ACC_W = 32;
  localparam int VL = 16;
  localparam int ADDR_W = 10;
  localparam int DATA_W = ACC_W * VL;
  typedef enum logic [1:0] {
    MODE_INT4_VSQ = 2'd0,
    MODE_INT8_PT  = 2'd1,
    MODE_INT8_PC  = 2'd2,
    MODE_INT8_BLK = 2'd3
  } mode_e;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_STREAM = 2'd2
  } feeder_state_e;
  function automatic logic two_pass(input mode_e m);
    return m != MODE_INT4_VSQ;
  endfunction
endpackage

// File: rtl/acc_feeder_if.sv
// acc_feeder_if: accumulator SRAM read port plus PPU vector stream
interface acc_feeder_if import ppu_pkg::*; ();
  logic              acc_rd_en;
  logic [ADDR_W-1:0] acc_rd_addr;
  logic [DATA_W-1:0] acc_rd_data;
  logic              ppu_start;
  logic [DATA_W-1:0] acc_data;
  logic              pass;
  modport master (output acc_rd_en, acc_rd_addr, ppu_start, acc_data, pass, input acc_rd_data);
  modport slave  (input acc_rd_en, acc_rd_addr, ppu_start, acc_data, pass, output acc_rd_data);
endinterface

// File: rtl/acc_addr_gen.sv
// acc_addr_gen: tile/index/pass counters producing the SRAM read address and end-of-tile/matrix flags
module acc_addr_gen import ppu_pkg::*; #(
  parameter int AD = 8,
  parameter int TILES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_launch,
  input  logic              i_step,
  input  logic              i_two_pass,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_tile_last,
  output logic              o_matrix_last,
  output logic              o_pass
);
  localparam int TW = TILES > 1 ? $clog2(TILES) : 1;
  localparam int IW = $clog2(AD + 1);
  logic [TW-1:0] tile_cnt;
  logic [IW-1:0] idx;
  logic last_tile;
  assign last_tile = tile_cnt == TW'(TILES - 1);
  assign o_tile_last = idx == IW'(AD);
  assign o_matrix_last = o_tile_last && last_tile && (!i_two_pass || o_pass);
  assign o_addr = ADDR_W'(tile_cnt) * ADDR_W'(AD) + ADDR_W'(idx);
  // idx returns to 0 at tile end so the launch address is the tile base
  always_ff @(posedge i_clk)
    if (i_rst || i_clr) begin
      tile_cnt <= '0;
      idx <= '0;
      o_pass <= 1'b0;
    end else if (i_launch) idx <= IW'(1);
    else if (i_step) begin
      if (!o_tile_last) idx <= idx + IW'(1);
      else begin
        idx <= '0;
        tile_cnt <= last_tile ? '0 : tile_cnt + TW'(1);
        if (last_tile) o_pass <= i_two_pass && !o_pass;
      end
    end
endmodule

// File: rtl/acc_feeder.sv
// acc_feeder: streams accumulator tiles into the PPU (two passes for INT8); ACC_FEEDER_PERF_EN adds o_hold_cycles
module acc_feeder import ppu_pkg::*; #(
  parameter int AD = 8,
  parameter int TILES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_mode,
  input  logic        i_hold,
  acc_feeder_if.master acc,
  output logic        o_busy,
  output logic        o_done
`ifdef ACC_FEEDER_PERF_EN
  ,
  output logic [31:0] o_hold_cycles
`endif
);
  feeder_state_e state;
  mode_e mode;
  logic done, accept, launch, stream, rd_en, tile_last, matrix_last, pass;
  logic [ADDR_W-1:0] addr;
  assign accept = state == S_IDLE && i_start;
  assign launch = state == S_LAUNCH && !i_hold;
  assign stream = state == S_STREAM;
  assign rd_en = launch || (stream && !tile_last);
  acc_addr_gen #(.AD(AD), .TILES(TILES)) u_gen (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(accept),
    .i_launch(launch),
    .i_step(stream),
    .i_two_pass(two_pass(mode)),
    .o_addr(addr),
    .o_tile_last(tile_last),
    .o_matrix_last(matrix_last),
    .o_pass(pass)
  );
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= S_IDLE;
      mode <= MODE_INT4_VSQ;
      done <= 1'b0;
    end else begin
      done <= stream && matrix_last;
      if (accept) begin
        mode <= mode_e'(i_mode);
        state <= S_LAUNCH;
      end else if (launch) state <= S_STREAM;
      else if (stream && tile_last) state <= matrix_last ? S_IDLE : S_LAUNCH;
    end
  assign acc.acc_rd_en = rd_en;
  assign acc.acc_rd_addr = rd_en ? addr : '0;
  assign acc.ppu_start = launch;
  assign acc.acc_data = stream ? acc.acc_rd_data : '0;
  assign acc.pass = pass;
  assign o_busy = state != S_IDLE;
  assign o_done = done;
`ifdef ACC_FEEDER_PERF_EN
  always_ff @(posedge i_clk)
    if (i_rst || accept) o_hold_cycles <= '0;
    else if (state == S_LAUNCH && i_hold && !(&o_hold_cycles)) o_hold_cycles <= o_hold_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_acc_feeder.sv
// tb_acc_feeder: randomized scoreboard bench for acc_feeder against a cycle-schedule reference model
module tb_acc_feeder;
  import ppu_pkg::*;
  localparam int AD = 4;
  localparam int TILES = 2;
  localparam int HM = 8192;
  typedef struct { int cyc; logic pass; } st_ev_t;
  typedef struct { int cyc; logic [ADDR_W-1:0] v; } rd_ev_t;
  typedef struct { int cyc; logic [DATA_W-1:0] v; } dat_ev_t;
  logic i_clk = 0, i_rst = 1, i_start = 0, i_hold = 0;
  logic [1:0] i_mode = '0;
  logic o_busy, o_done;
`ifdef ACC_FEEDER_PERF_EN
  logic [31:0] o_hold_cycles;
`endif
  acc_feeder_if bus();
  acc_feeder #(.AD(AD), .TILES(TILES)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_mode(i_mode),
    .i_hold(i_hold),
    .acc(bus),
    .o_busy(o_busy),
    .o_done(o_done)
`ifdef ACC_FEEDER_PERF_EN
    ,
    .o_hold_cycles(o_hold_cycles)
`endif
  );
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_q = '0;
  always @(posedge i_clk) if (bus.acc_rd_en) rd_data_q <= mem[bus.acc_rd_addr];
  assign bus.acc_rd_data = rd_data_q;
  bit hold_map [0:HM-1];
  st_ev_t st_q[$];
  rd_ev_t rd_q[$];
  dat_ev_t dat_q[$];
  int dn_q[$];
  int busy_lo = 1, busy_hi = 0, pass_lo = 1, pass_hi = 0;
  int exp_hold = 0, last_done = -1;
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask
  initial forever begin
    @(posedge i_clk);
    #1;
    i_hold = cyc < HM ? hold_map[cyc] : 1'b0;
  end
  bit e_st, e_rd, e_dat, e_dn;
  always @(negedge i_clk) begin
    e_st = st_q.size() != 0 && st_q[0].cyc == cyc;
    chk("ppu_start", DATA_W'(bus.ppu_start), DATA_W'(e_st));
    if (e_st) begin
      chk("start_pass", DATA_W'(bus.pass), DATA_W'(st_q[0].pass));
      void'(st_q.pop_front());
    end
    e_rd = rd_q.size() != 0 && rd_q[0].cyc == cyc;
    chk("rd_en", DATA_W'(bus.acc_rd_en), DATA_W'(e_rd));
    chk("rd_addr", DATA_W'(bus.acc_rd_addr), e_rd ? DATA_W'(rd_q[0].v) : '0);
    if (e_rd) void'(rd_q.pop_front());
    e_dat = dat_q.size() != 0 && dat_q[0].cyc == cyc;
    chk("acc_data", bus.acc_data, e_dat ? dat_q[0].v : '0);
    if (e_dat) void'(dat_q.pop_front());
    e_dn = dn_q.size() != 0 && dn_q[0] == cyc;
    chk("done", DATA_W'(o_done), DATA_W'(e_dn));
    if (e_dn) begin
      last_done = cyc;
      void'(dn_q.pop_front());
    end
    chk("busy", DATA_W'(o_busy), DATA_W'(cyc >= busy_lo && cyc <= busy_hi));
    chk("pass", DATA_W'(bus.pass), DATA_W'(cyc >= pass_lo && cyc <= pass_hi));
  end
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic fill_mem(input bit seq);
    for (int i = 0; i < TILES * AD; i++)
      for (int l = 0; l < VL; l++)
        mem[i][l*ACC_W +: ACC_W] = seq ? (l == 0 ? ACC_W'(i) : '0) : $urandom;
  endtask
  task automatic fill_hold(input int from, input int pct);
    for (int i = from; i < from + 200 && i < HM; i++) hold_map[i] = $urandom_range(99) < pct;
  endtask
  // Reference schedule: each tile launches, waits out hold, then streams AD vectors
  task automatic plan(input mode_e m, input int c0, output int td);
    int t, np;
    t = c0 + 1;
    np = m != MODE_INT4_VSQ ? 2 : 1;
    exp_hold = 0;
    busy_lo = c0 + 1;
    pass_lo = 1;
    pass_hi = 0;
    for (int p = 0; p < np; p++)
      for (int tl = 0; tl < TILES; tl++) begin
        if (p == 1 && tl == 0) pass_lo = t;
        while (t < HM && hold_map[t]) begin
          t++;
          exp_hold++;
        end
        st_q.push_back('{t, p == 1});
        rd_q.push_back('{t, ADDR_W'(tl * AD)});
        for (int k = 0; k < AD; k++) begin
          dat_q.push_back('{t + 1 + k, mem[tl * AD + k]});
          if (k < AD - 1) rd_q.push_back('{t + 1 + k, ADDR_W'(tl * AD + k + 1)});
        end
        t += AD + 1;
      end
    busy_hi = t - 1;
    if (np == 2) pass_hi = t - 1;
    dn_q.push_back(t);
    td = t;
  endtask
  task automatic run(input mode_e m, input bit spur, output int c0, output int td);
    int sp;
    c0 = cyc;
    i_mode = m;
    i_start = 1;
    plan(m, c0, td);
    sp = spur ? int'($urandom_range(td - 1, c0 + 1)) : -1;
    step();
    i_start = 0;
    while (cyc < td) begin
      i_start = cyc == sp;
      i_mode = 2'($urandom);
      step();
    end
    i_start = 0;
`ifdef ACC_FEEDER_PERF_EN
    chk("hold_cycles", DATA_W'(o_hold_cycles), DATA_W'(exp_hold));
`endif
  endtask
  task automatic abort_run(input mode_e m);
    int c0, td, lim;
    c0 = cyc;
    i_mode = m;
    i_start = 1;
    plan(m, c0, td);
    step();
    i_start = 0;
    step();
    step();
    lim = c0 + 3;
    i_rst = 1;
    while (st_q.size() != 0 && st_q[$].cyc > lim) void'(st_q.pop_back());
    while (rd_q.size() != 0 && rd_q[$].cyc > lim) void'(rd_q.pop_back());
    while (dat_q.size() != 0 && dat_q[$].cyc > lim) void'(dat_q.pop_back());
    while (dn_q.size() != 0 && dn_q[$] > lim) void'(dn_q.pop_back());
    if (busy_hi > lim) busy_hi = lim;
    if (pass_hi > lim) pass_hi = lim;
    step();
    i_rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end
  initial begin
    int c0, td;
    fill_mem(1);
    repeat (3) step();
    i_rst = 0;
    step();
    fill_hold(cyc, 0);
    run(MODE_INT4_VSQ, 0, c0, td);
    step();
    chk("int4_done_offset", DATA_W'(last_done - c0), DATA_W'(11));
    fill_hold(cyc, 0);
    run(MODE_INT8_PT, 0, c0, td);
    step();
    chk("int8_done_offset", DATA_W'(last_done - c0), DATA_W'(21));
    fill_hold(cyc, 0);
    for (int i = 6; i <= 8; i++) hold_map[cyc + i] = 1;
    run(MODE_INT4_VSQ, 0, c0, td);
    step();
    chk("hold_done_offset", DATA_W'(last_done - c0), DATA_W'(14));
`ifdef ACC_FEEDER_PERF_EN
    chk("hold_cycles_3", DATA_W'(o_hold_cycles), DATA_W'(3));
`endif
    fill_hold(cyc, 0);
    abort_run(MODE_INT8_PC);
    step();
    run(MODE_INT4_VSQ, 1, c0, td);
    run(MODE_INT8_BLK, 1, c0, td);
    run(MODE_INT4_VSQ, 0, c0, td);
    step();
    for (int n = 0; n < 24; n++) begin
      fill_mem(0);
      fill_hold(cyc, int'($urandom_range(30)));
      run(mode_e'($urandom_range(3)), 1'($urandom_range(1)), c0, td);
      if ($urandom_range(1) == 1) repeat ($urandom_range(3)) step();
    end
    repeat (3) step();
    chk("queues_drained", DATA_W'(st_q.size() + rd_q.size() + dat_q.size() + dn_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acc_feeder.md
Name: acc_feeder

Overview:
- Initiator side of the PPU input interface: reads accumulator vectors from the accumulator SRAM and drives the PPU start pulse plus the per-cycle accumulator vector stream.
- Sits between the systolic-array accumulator buffer and the PPU.
- Issues one tile as a start pulse followed by AD consecutive vectors.
- Replays the whole matrix twice for INT8 modes: a max pass, then a calc pass.

Parameters:
- VL, 16, lanes per vector.
- ACC_W, 32, bits per accumulator lane.
- AD, 8, vectors per tile; must be ≥2.
- TILES, 4, tiles per matrix, equal to (M/VL)*(N/AD).
- ADDR_W, 10, accumulator SRAM address width; must be ≥ clog2(TILES*AD).
- MODE_INT4_VSQ, 2'd0, mode encoding that needs a single pass.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  pulse; begins a matrix; accepted only in S_IDLE.
- i_mode  in  2  matrix mode; latched at accept.
- i_hold  in  1  downstream not ready; sampled only in S_LAUNCH.
- o_acc_rd_en  out  1  SRAM read enable.
- o_acc_rd_addr  out  ADDR_W  SRAM read address.
- i_acc_rd_data  in  ACC_W*VL  SRAM read data; valid 1 cycle after o_acc_rd_en.
- o_ppu_start  out  1  PPU start pulse.
- o_acc_data  out  ACC_W*VL  vector to PPU.
- o_pass  out  1  0 = max pass, 1 = calc pass.
- o_busy  out  1  high outside S_IDLE.
- o_done  out  1  1-cycle pulse when the matrix completes.

Behaviour:
- Reset: every output is 0; state S_IDLE; tile_cnt, idx, pass and the latched mode are 0.
  - Reset mid-operation aborts immediately, with no o_done.
  - The PPU must be reset in the same cycle; the block does not resynchronise with a PPU that has not been reset.
- S_IDLE:
  - On i_start: latch i_mode, clear tile_cnt, pass and idx, go to S_LAUNCH.
  - o_done is high in the first S_IDLE cycle after completion. i_start in that same cycle is accepted.
- S_LAUNCH:
  - If i_hold is high: stay; no start pulse, no read.
  - Else: o_ppu_start=1, o_acc_rd_en=1, addr = tile_cnt*AD; idx←1; go to S_STREAM.
- S_STREAM, AD cycles with stream index k = 0..AD-1:
  - o_acc_data = i_acc_rd_data, a combinational pass-through of vector k.
  - If k < AD-1: o_acc_rd_en=1, addr = tile_cnt*AD + k + 1.
  - On k = AD-1, tile is done:
    - If tile_cnt < TILES-1: tile_cnt++ and go to S_LAUNCH.
    - Else if mode != MODE_INT4_VSQ and pass==0: pass←1, tile_cnt←0, go to S_LAUNCH.
    - Else: go to S_IDLE and assert o_done next cycle.
- Outside S_STREAM, o_acc_data is 0.
- Resulting PPU timing: start at cycle t, vectors at t+1..t+AD, next start no earlier than t+AD+1. Tile period is AD+1 cycles when i_hold is low. This matches a PPU that returns to idle one cycle after its AD-th vector.
- i_start while busy is ignored. i_hold outside S_LAUNCH is ignored; a tile is never interrupted once started.
- Address arithmetic is unsigned ADDR_W with no wrap, because TILES*AD ≤ 2^ADDR_W.
- o_pass holds for the whole pass and clears on return to S_IDLE.

Optional Feature:
- Macro ACC_FEEDER_PERF_EN.
- When defined: extra output o_hold_cycles (32 bits) counts S_LAUNCH cycles with i_hold high.
  - Cleared on reset and on i_start accept; saturates at all-ones.
- When undefined: no port and no counter logic.

Decomposition:
- Shared package ppu_pkg holds:
  - mode encodings (INT4_VSQ etc.);
  - the acc_feeder state encoding S_IDLE/S_LAUNCH/S_STREAM;
  - widths ACC_W, VL, ADDR_W, taken from the existing global defines.
- One natural sub-module, acc_addr_gen: holds the tile_cnt/idx/pass counters and produces the address, tile_last and matrix_last flags.
- The FSM stays in acc_feeder.

Test Plan:
- AD=4, TILES=2, mode INT4_VSQ, i_start at cycle 0, no hold:
  - o_ppu_start at cycles 1 and 6;
  - rd_addr 0,1,2,3 at cycles 1–4 and 4,5,6,7 at cycles 6–9;
  - o_done at cycle 11; o_busy low from cycle 11.
- Same setup with mode INT8:
  - 4 start pulses at cycles 1, 6, 11, 16;
  - address sequence 0..7 twice;
  - o_pass 0 then 1 (rises at cycle 11);
  - o_done at cycle 21.
- i_hold high for cycles 6–8 in the INT4_VSQ run: second start moves to cycle 9; no rd_en in cycles 6–8; o_done at cycle 14.
- SRAM model returns data = address: o_acc_data equals 0,1,2,3 in cycles 2–5, and is 0 in S_LAUNCH/S_IDLE.
- i_rst at cycle 3: from cycle 4 all outputs are 0 and o_busy is 0; a new i_start restarts at address 0 with no o_done from the aborted run.
- i_start pulsed at cycle 4 while busy: ignored. i_start on the o_done cycle: accepted, with o_ppu_start the next cycle. With ACC_FEEDER_PERF_EN, o_hold_cycles = 3 after the hold test.
